// File: rtl/qed_dup_buffer_if.sv
// qed_dup_buffer_if
//   Bundles the fetch-side control/instruction signals and the core-side
//   outputs of qed_dup_buffer.
//   master : fetch/rewrite logic (drives ena, exec_dup, stall, instructions)
//   slave  : qed_dup_buffer (drives qed_ifu_instruction, qed_vld_out, status)
interface qed_dup_buffer_if #(
    parameter int ADDR_W = 4
);
    logic              ena;
    logic              exec_dup;
    logic              stall;
    logic [31:0]       ifu_qed_instruction;
    logic [31:0]       qed_dup_instruction;
    logic              is_supported;
    logic [31:0]       qed_ifu_instruction;
    logic              qed_vld_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output ena, exec_dup, stall, ifu_qed_instruction, qed_dup_instruction, is_supported,
        input  qed_ifu_instruction, qed_vld_out, count, full, empty, overflow
    );

    modport slave (
        input  ena, exec_dup, stall, ifu_qed_instruction, qed_dup_instruction, is_supported,
        output qed_ifu_instruction, qed_vld_out, count, full, empty, overflow
    );
endinterface

// File: rtl/qed_dup_buffer.sv
// qed_dup_buffer
//   Duplicate-instruction queue for the SQED fetch path. In original mode the
//   fetched instruction is forwarded and its register-remapped duplicate is
//   queued (unsupported instructions become a NOP). In duplicate mode the
//   queued duplicates are replayed in program order.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : qed_dup_buffer_if.slave
//           in : ena, exec_dup, stall, ifu_qed_instruction,
//                qed_dup_instruction, is_supported
//           out: qed_ifu_instruction (registered), qed_vld_out, count,
//                full, empty, overflow (sticky)
module qed_dup_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    qed_dup_buffer_if.slave   bus
);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       instr_q, instr_d;
    logic              vld_q, vld_d;
    logic              ovf_q, ovf_d;
    logic              push;
    logic              full_w, empty_w;

    // Occupancy is kept separately from the pointers so that head == tail
    // is never ambiguous between full and empty.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        if (!bus.stall) begin
            if (!bus.ena) begin
                // Pass-through also flushes the queue.
                instr_d = bus.ifu_qed_instruction;
                vld_d   = 1'b1;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else if (!bus.exec_dup) begin
                if (!bus.is_supported) begin
                    instr_d = NOP;
                    vld_d   = 1'b1;
                end else if (full_w) begin
                    // Cannot record the duplicate: drop the original too and
                    // flag the loss.
                    instr_d = NOP;
                    vld_d   = 1'b0;
                    ovf_d   = 1'b1;
                end else begin
                    instr_d = bus.ifu_qed_instruction;
                    vld_d   = 1'b1;
                    push    = 1'b1;
                    tail_d  = tail_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W + 1)'(1);
                end
            end else begin
                if (empty_w) begin
                    instr_d = NOP;
                    vld_d   = 1'b0;
                end else begin
                    instr_d = mem_q[head_q];
                    vld_d   = 1'b1;
                    head_d  = head_q + ADDR_W'(1);
                    count_d = count_q - (ADDR_W + 1)'(1);
                end
            end
        end
    end

    // Storage carries no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= bus.qed_dup_instruction;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            instr_q <= NOP;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.qed_ifu_instruction = instr_q;
    assign bus.qed_vld_out         = vld_q;
    assign bus.count               = count_q;
    assign bus.full                = full_w;
    assign bus.empty               = empty_w;
    assign bus.overflow            = ovf_q;
endmodule
